div_radix2_unit: RTL and testbench

//  Iterative radix-2 restoring divider in the EX stage. It executes DIV/DIVU,

---
 rtl/div_radix2_unit.sv | 147 ++++++++++++++
 tb/tb_div_radix2_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/div_radix2_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX.
// Produces {remainder, quotient}, and holds the pipeline while the divide runs.
module div_radix2_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               stall_div,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r, stateNext_s;
  logic [CW-1:0]       cnt_r;
  logic [WIDTH-1:0]    dividend_r, divisor_r, partRem_r, quot_r;
  logic                negQuot_r, negRem_r;
  logic [2*WIDTH-1:0]  result_r;
  logic [WIDTH:0]      trial_s;
  logic [WIDTH-1:0]    shifted_s, remNext_s, quotNext_s;
  logic                qBit_s, accept_s;

  function automatic logic [WIDTH-1:0] negCond(input logic [WIDTH-1:0] v, input logic neg);
    negCond = neg ? (~v + ONE) : v;
  endfunction

  function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v, input logic sgn);
    absVal = negCond(v, sgn & v[WIDTH-1]);
  endfunction

  assign accept_s = start & ~flush;

  // One restoring step: the shifted remainder is below 2*|b|, so WIDTH+1 bits suffice.
  assign trial_s    = {partRem_r, dividend_r[WIDTH-1]} - {1'b0, divisor_r};
  assign shifted_s  = {partRem_r[WIDTH-2:0], dividend_r[WIDTH-1]};
  assign qBit_s     = ~trial_s[WIDTH];
  assign remNext_s  = qBit_s ? trial_s[WIDTH-1:0] : shifted_s;
  assign quotNext_s = {quot_r[WIDTH-2:0], qBit_s};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state decode plus the stall and ready outputs.
  always_comb begin
    stateNext_s = state_r;
    stall_div   = 1'b0;
    ready       = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          stall_div   = 1'b1;
          stateNext_s = (b == ZERO) ? DONE : CALC;
        end else begin
          stateNext_s = IDLE;
        end
      end
      CALC: begin
        stall_div = 1'b1;
        if (flush) begin
          stateNext_s = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          stateNext_s = DONE;
        end else begin
          stateNext_s = CALC;
        end
      end
      DONE: begin
        ready       = ~flush;
        stateNext_s = IDLE;
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= '0;
      dividend_r <= '0;
      divisor_r  <= '0;
      partRem_r  <= '0;
      quot_r     <= '0;
      negQuot_r  <= 1'b0;
      negRem_r   <= 1'b0;
      result_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (b == ZERO) begin
              result_r <= {a, {WIDTH{1'b1}}};
            end else begin
              dividend_r <= absVal(a, is_signed);
              divisor_r  <= absVal(b, is_signed);
              partRem_r  <= '0;
              quot_r     <= '0;
              cnt_r      <= '0;
              negQuot_r  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              negRem_r   <= is_signed & a[WIDTH-1];
            end
          end
        end
        CALC: begin
          if (!flush) begin
            dividend_r <= {dividend_r[WIDTH-2:0], 1'b0};
            partRem_r  <= remNext_s;
            quot_r     <= quotNext_s;
            cnt_r      <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              result_r <= {negCond(remNext_s, negRem_r), negCond(quotNext_s, negQuot_r)};
            end
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign result = result_r;

endmodule

// File: tb/tb_div_radix2_unit.sv
// Directed and random bench for div_radix2_unit; expected results are queued
// when a divide is launched and compared when ready pulses.
module tb_div_radix2_unit;

  logic        clk, rst, start, isSigned, flush;
  logic [31:0] a, b;
  logic        stallDiv, ready;
  logic [63:0] result;

  int          nCmp = 0;
  int          nErr = 0;
  logic [63:0] sbQ[$];
  logic [63:0] lastRes;

  div_radix2_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(isSigned),
    .a(a), .b(b), .flush(flush),
    .stall_div(stallDiv), .ready(ready), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] q, r;
    if (bv == 32'd0) return {av, 32'hFFFFFFFF};
    if (!sgn) begin
      q = av / bv;
      r = av % bv;
    end else if (av == 32'h80000000 && bv == 32'hFFFFFFFF) begin
      q = 32'h80000000;
      r = 32'd0;
    end else begin
      q = $signed(av) / $signed(bv);
      r = $signed(av) % $signed(bv);
    end
    return {r, q};
  endfunction

  // Launch one divide, keep start high while stalled, check latency, stall length and result.
  task automatic doDiv(input string tag, input logic sgn, input logic [31:0] av,
                       input logic [31:0] bv, input logic [63:0] expv, input int expLat);
    int stalls = 0;
    int lat = -1;
    logic [63:0] want;
    @(negedge clk);
    start = 1'b1; isSigned = sgn; a = av; b = bv;
    sbQ.push_back(expv);
    for (int c = 0; c <= 40 && lat < 0; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (stallDiv) stalls++;
      if (c == 3) begin
        a = ~av; b = ~bv;
      end
      if (ready) begin
        lat = c;
        check({tag, "_stall_at_ready"}, {63'd0, stallDiv}, 64'd0);
        want = (sbQ.size() > 0) ? sbQ.pop_front() : 64'hDEADBEEF_DEADBEEF;
        check({tag, "_result"}, result, want);
        lastRes = want;
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(expLat));
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(expLat));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          readyCnt;
    rst = 1'b1; start = 1'b0; isSigned = 1'b0; flush = 1'b0; a = 32'd0; b = 32'd0;
    lastRes = 64'd0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_stall", {63'd0, stallDiv}, 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    doDiv("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    doDiv("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    doDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 33);
    doDiv("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
    doDiv("divu_min_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 33);
    doDiv("div_by_zero", 1'b0, 32'h1234, 32'd0, {32'h1234, 32'hFFFFFFFF}, 1);

    // Flush in the middle of CALC.
    @(negedge clk);
    start = 1'b1; isSigned = 1'b0; a = 32'd1000; b = 32'd3;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_stall", {63'd0, stallDiv}, 64'd0);
    check("flush_ready", {63'd0, ready}, 64'd0);
    check("flush_result_kept", result, lastRes);
    readyCnt = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (ready) readyCnt++;
    end
    check("flush_no_pulse", 64'(readyCnt), 64'd0);
    doDiv("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Flush together with start in IDLE: a divide-by-zero would pulse next cycle.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; a = 32'd5; b = 32'd0;
    #1;
    check("flush_start_stall", {63'd0, stallDiv}, 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush_start_ready", {63'd0, ready}, 64'd0);

    // Flush in DONE suppresses the ready pulse.
    @(negedge clk);
    start = 1'b1; isSigned = 1'b0; a = 32'd77; b = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    #1;
    check("flush_done_ready", {63'd0, ready}, 64'd0);
    check("flush_done_stall", {63'd0, stallDiv}, 64'd0);
    @(negedge clk);
    flush = 1'b0;

    // Reset in cycle 5 of CALC.
    @(negedge clk);
    start = 1'b1; isSigned = 1'b0; a = 32'd500; b = 32'd9;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_stall", {63'd0, stallDiv}, 64'd0);
    check("rst_mid_ready", {63'd0, ready}, 64'd0);
    check("rst_mid_result", result, 64'd0);
    rst = 1'b0;
    lastRes = 64'd0;

    doDiv("b2b_50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);
    doDiv("b2b_17_4", 1'b0, 32'd17, 32'd4, {32'd1, 32'd4}, 33);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? ($urandom >> $urandom_range(31, 0)) : $urandom;
      if (rb == 32'd0) rb = 32'd3;
      rs = i[0] ^ i[1];
      doDiv("random", rs, ra, rb, model(rs, ra, rb), 33);
    end

    check("scoreboard_empty", 64'(sbQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nErr);
    $finish;
  end

endmodule
